// File: rtl/agu_dtlb_if.sv
// agu_dtlb_if: lookup and refill-write bundle for the data-side TLB.
//   master : AGU / page-walk side. It drives the lookup request and the refill write,
//            and it receives the translation result.
//   slave  : the TLB itself.
// Lookup : read_clkEn, sec_wren, addr[51:0], sproc[20:0]
//          -> read_data, read_data_next, read_way[2:0], read_hit
// Refill : write_addr[50:0], write_data0/1/2, force_way[2:0], force_way_en,
//          write_xstant, write_invl, write_wen
interface agu_dtlb_if #(
    parameter int DATA_WIDTH = 38
);
    logic                  read_clkEn;
    logic                  sec_wren;
    logic [51:0]           addr;
    logic [20:0]           sproc;
    logic [DATA_WIDTH-1:0] read_data;
    logic [DATA_WIDTH-1:0] read_data_next;
    logic [2:0]            read_way;
    logic                  read_hit;
    logic [50:0]           write_addr;
    logic [DATA_WIDTH-1:0] write_data0;
    logic [DATA_WIDTH-1:0] write_data1;
    logic [DATA_WIDTH-1:0] write_data2;
    logic [2:0]            force_way;
    logic                  force_way_en;
    logic                  write_xstant;
    logic                  write_invl;
    logic                  write_wen;

    modport master (
        output read_clkEn, sec_wren, addr, sproc,
        output write_addr, write_data0, write_data1, write_data2,
        output force_way, force_way_en, write_xstant, write_invl, write_wen,
        input  read_data, read_data_next, read_way, read_hit
    );

    modport slave (
        input  read_clkEn, sec_wren, addr, sproc,
        input  write_addr, write_data0, write_data1, write_data2,
        input  force_way, force_way_en, write_xstant, write_invl, write_wen,
        output read_data, read_data_next, read_way, read_hit
    );
endinterface

// File: rtl/agu_dtlb.sv
// agu_dtlb: 8-way, 32-set data TLB. Each entry covers an aligned pair of 8 KB pages.
// An entry holds the translation words for the even page, the odd page and the next
// pair's even page. A lookup therefore returns the addressed page and the following
// page at the same time.
// Ports:
//   clk, rst   : clock and synchronous active-high reset
//   bus        : agu_dtlb_if.slave
//                - combinational lookup: addr/sproc -> read_hit/read_way/read_data/read_data_next
//                - synchronous refill write: write_* / force_way*
module agu_dtlb #(
    parameter int DATA_WIDTH = 38,
    parameter int WAYS       = 8,
    parameter int SETS       = 32
) (
    input  logic      clk,
    input  logic      rst,
    agu_dtlb_if.slave bus
);
    localparam int TAG_W = 46;

    // Entry state. valid/sticky/round-robin are reset; tags and data are not,
    // because they are only observed through a valid bit.
    logic [SETS-1:0][WAYS-1:0] valid_reg;
    logic [SETS-1:0][WAYS-1:0] sticky_reg;
    logic [2:0]                rr_reg    [SETS];
    logic [TAG_W-1:0]          tag_mem   [SETS][WAYS];
    logic [DATA_WIDTH-1:0]     data0_mem [SETS][WAYS];
    logic [DATA_WIDTH-1:0]     data1_mem [SETS][WAYS];
    logic [DATA_WIDTH-1:0]     data2_mem [SETS][WAYS];

    // ---------------- lookup ----------------
    logic [50:0]      rd_pair;
    logic [4:0]       rd_set;
    logic [TAG_W-1:0] rd_tag;
    logic [WAYS-1:0]  rd_match;
    logic             rd_any;
    logic [2:0]       rd_way;

    assign rd_pair = bus.addr[51:1];
    assign rd_set  = rd_pair[4:0];
    // The process id part of the tag is XORed with sproc. Refill writes arrive pre-XORed.
    assign rd_tag  = {rd_pair[50:30] ^ bus.sproc, rd_pair[29:5]};

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_rd_match
            assign rd_match[gi] = valid_reg[rd_set][gi] && (tag_mem[rd_set][gi] == rd_tag);
        end
    endgenerate

    // The loop scans downward, so the lowest matching way is the one that remains.
    always_comb begin
        rd_any = 1'b0;
        rd_way = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (rd_match[w]) begin
                rd_any = 1'b1;
                rd_way = w[2:0];
            end
        end
    end

    always_comb begin
        bus.read_data      = '0;
        bus.read_data_next = '0;
        bus.read_way       = '0;
        bus.read_hit       = rd_any && bus.read_clkEn && bus.sec_wren;
        if (rd_any) begin
            bus.read_way = rd_way;
            if (bus.addr[0]) begin
                bus.read_data      = data1_mem[rd_set][rd_way];
                bus.read_data_next = data2_mem[rd_set][rd_way];
            end else begin
                bus.read_data      = data0_mem[rd_set][rd_way];
                bus.read_data_next = data1_mem[rd_set][rd_way];
            end
        end
    end

    // ---------------- refill write ----------------
    logic [4:0]       wr_set;
    logic [TAG_W-1:0] wr_tag;
    logic [WAYS-1:0]  wr_valid;
    logic [WAYS-1:0]  wr_sticky;
    logic [WAYS-1:0]  wr_inv_match;
    logic [2:0]       rr_ptr;
    logic             inv_found;
    logic [2:0]       inv_way;
    logic             rr_found;
    logic [2:0]       rr_way;
    logic [2:0]       rr_cand;
    logic             victim_ok;
    logic [2:0]       victim;

    assign wr_set    = bus.write_addr[4:0];
    assign wr_tag    = bus.write_addr[50:5];
    assign wr_valid  = valid_reg[wr_set];
    assign wr_sticky = sticky_reg[wr_set];
    assign rr_ptr    = rr_reg[wr_set];

    generate
        for (genvar gi = 0; gi < WAYS; gi++) begin : g_inv_match
            assign wr_inv_match[gi] = wr_valid[gi] && (tag_mem[wr_set][gi] == wr_tag);
        end
    endgenerate

    // Find the lowest invalid way. Also find the first non-sticky way at or after the
    // round-robin pointer, wrapping mod 8.
    always_comb begin
        inv_found = 1'b0;
        inv_way   = '0;
        rr_found  = 1'b0;
        rr_way    = '0;
        rr_cand   = '0;
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!wr_valid[w]) begin
                inv_found = 1'b1;
                inv_way   = w[2:0];
            end
        end
        for (int k = WAYS - 1; k >= 0; k--) begin
            rr_cand = rr_ptr + k[2:0];
            if (!wr_sticky[rr_cand]) begin
                rr_found = 1'b1;
                rr_way   = rr_cand;
            end
        end
    end

    // Victim priority: forced way, then an invalid way, then round-robin.
    // Selection uses the pre-write valid bits. If no way qualifies, the write is dropped.
    always_comb begin
        victim_ok = 1'b0;
        victim    = '0;
        if (bus.force_way_en) begin
            victim_ok = 1'b1;
            victim    = bus.force_way;
        end else if (inv_found) begin
            victim_ok = 1'b1;
            victim    = inv_way;
        end else if (rr_found) begin
            victim_ok = 1'b1;
            victim    = rr_way;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_reg  <= '0;
            sticky_reg <= '0;
            for (int s = 0; s < SETS; s++) begin
                rr_reg[s] <= '0;
            end
        end else if (bus.write_wen) begin
            if (bus.write_invl) begin
                for (int w = 0; w < WAYS; w++) begin
                    if (wr_inv_match[w]) begin
                        valid_reg[wr_set][w]  <= 1'b0;
                        sticky_reg[wr_set][w] <= 1'b0;
                    end
                end
            end
            // Placed after the invalidation, so the victim ends up valid even if it matched.
            if (victim_ok) begin
                valid_reg[wr_set][victim]  <= 1'b1;
                sticky_reg[wr_set][victim] <= bus.write_xstant;
            end
            if (!bus.force_way_en) begin
                rr_reg[wr_set] <= rr_reg[wr_set] + 3'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst && bus.write_wen && victim_ok) begin
            tag_mem[wr_set][victim]   <= wr_tag;
            data0_mem[wr_set][victim] <= bus.write_data0;
            data1_mem[wr_set][victim] <= bus.write_data1;
            data2_mem[wr_set][victim] <= bus.write_data2;
        end
    end
endmodule

// File: tb/tb_agu_dtlb.sv
module tb_agu_dtlb;
    localparam int DW = 38;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    agu_dtlb_if #(.DATA_WIDTH(DW)) bus ();

    agu_dtlb #(.DATA_WIDTH(DW), .WAYS(8), .SETS(32)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string          name;
        logic           hit;
        logic [2:0]     way;
        logic [DW-1:0]  d;
        logic [DW-1:0]  n;
        logic           chk_data;
    } exp_t;

    exp_t sb[$];

    // Compares the DUT outputs against the oldest expectation in the scoreboard.
    task automatic compare_head();
        exp_t e;
        e = sb.pop_front();
        checks++;
        assert (bus.read_hit === e.hit) else begin
            failures++;
            $error("FAIL %s read_hit got=%0b exp=%0b", e.name, bus.read_hit, e.hit);
        end
        if (e.chk_data) begin
            checks++;
            assert (bus.read_way === e.way) else begin
                failures++;
                $error("FAIL %s read_way got=%0d exp=%0d", e.name, bus.read_way, e.way);
            end
            checks++;
            assert (bus.read_data === e.d) else begin
                failures++;
                $error("FAIL %s read_data got=%h exp=%h", e.name, bus.read_data, e.d);
            end
            checks++;
            assert (bus.read_data_next === e.n) else begin
                failures++;
                $error("FAIL %s read_data_next got=%h exp=%h", e.name, bus.read_data_next, e.n);
            end
        end
        $display("lookup %s addr=%h sproc=%h hit=%0b way=%0d data=%h next=%h",
                 e.name, bus.addr, bus.sproc, bus.read_hit, bus.read_way,
                 bus.read_data, bus.read_data_next);
    endtask

    // Drives a lookup in the current cycle, queues the expected result, then samples it 1 ns later.
    task automatic drive_lookup(input string name, input logic [51:0] a, input logic [20:0] sp,
                                input logic ce, input logic sec, input logic eh,
                                input logic [2:0] ew, input logic [DW-1:0] ed,
                                input logic [DW-1:0] en, input logic cd);
        exp_t e;
        bus.addr       = a;
        bus.sproc      = sp;
        bus.read_clkEn = ce;
        bus.sec_wren   = sec;
        e.name = name; e.hit = eh; e.way = ew; e.d = ed; e.n = en; e.chk_data = cd;
        sb.push_back(e);
        #1;
        compare_head();
    endtask

    task automatic lookup(input string name, input logic [51:0] a, input logic [20:0] sp,
                          input logic ce, input logic sec, input logic eh,
                          input logic [2:0] ew, input logic [DW-1:0] ed,
                          input logic [DW-1:0] en, input logic cd);
        @(negedge clk);
        drive_lookup(name, a, sp, ce, sec, eh, ew, ed, en, cd);
    endtask

    task automatic set_write(input logic [50:0] wa, input logic [DW-1:0] d0,
                             input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                             input logic fe, input logic [2:0] fw,
                             input logic xs, input logic inv);
        bus.write_addr   = wa;
        bus.write_data0  = d0;
        bus.write_data1  = d1;
        bus.write_data2  = d2;
        bus.force_way_en = fe;
        bus.force_way    = fw;
        bus.write_xstant = xs;
        bus.write_invl   = inv;
        bus.write_wen    = 1'b1;
    endtask

    task automatic do_write(input logic [50:0] wa, input logic [DW-1:0] d0,
                            input logic [DW-1:0] d1, input logic [DW-1:0] d2,
                            input logic fe, input logic [2:0] fw,
                            input logic xs, input logic inv);
        @(negedge clk);
        set_write(wa, d0, d1, d2, fe, fw, xs, inv);
        $display("write addr=%h force=%0b/%0d xstant=%0b invl=%0b d0=%h",
                 wa, fe, fw, xs, inv, d0);
        @(negedge clk);
        bus.write_wen = 1'b0;
    endtask

    // Page-pair address for a given 46-bit tag and set, with sproc = 0.
    function automatic logic [50:0] pair(input logic [45:0] tag, input logic [4:0] set);
        return {tag, set};
    endfunction

    logic [50:0] p1, p2, wa;
    logic [DW-1:0] z;

    initial begin
        checks = 0;
        failures = 0;
        z = '0;
        rst = 1'b1;
        bus.read_clkEn = 1'b0; bus.sec_wren = 1'b0; bus.addr = '0; bus.sproc = '0;
        bus.write_addr = '0; bus.write_data0 = '0; bus.write_data1 = '0; bus.write_data2 = '0;
        bus.force_way = '0; bus.force_way_en = 1'b0; bus.write_xstant = 1'b0;
        bus.write_invl = 1'b0; bus.write_wen = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // Reset state: no entry is valid.
        lookup("reset_miss0", 52'h0, 21'h0, 1'b1, 1'b1, 1'b0, 3'd0, z, z, 1'b1);
        lookup("reset_miss1", {51'h12345, 1'b1}, 21'h0, 1'b1, 1'b1, 1'b0, 3'd0, z, z, 1'b1);

        // Basic refill followed by lookups of the even and odd pages.
        p1 = 51'h12345;
        do_write(p1, 38'hA, 38'hB, 38'hC, 1'b0, 3'd0, 1'b0, 1'b0);
        lookup("basic_even", {p1, 1'b0}, 21'h0, 1'b1, 1'b1, 1'b1, 3'd0, 38'hA, 38'hB, 1'b1);
        lookup("basic_odd",  {p1, 1'b1}, 21'h0, 1'b1, 1'b1, 1'b1, 3'd0, 38'hB, 38'hC, 1'b1);
        lookup("sec_off",    {p1, 1'b0}, 21'h0, 1'b1, 1'b0, 1'b0, 3'd0, z, z, 1'b0);
        lookup("clken_off",  {p1, 1'b0}, 21'h0, 1'b0, 1'b1, 1'b0, 3'd0, z, z, 1'b0);
        lookup("sproc_miss", {p1, 1'b0}, 21'h1, 1'b1, 1'b1, 1'b0, 3'd0, z, z, 1'b1);

        // A lookup in the same cycle as the write sees the old contents; the next cycle sees the new entry.
        p2 = 51'h22345;
        @(negedge clk);
        set_write(p2, 38'h77, 38'h78, 38'h79, 1'b0, 3'd0, 1'b0, 1'b0);
        drive_lookup("same_cycle_old", {p2, 1'b0}, 21'h0, 1'b1, 1'b1, 1'b0, 3'd0, z, z, 1'b1);
        @(negedge clk);
        bus.write_wen = 1'b0;
        drive_lookup("after_write", {p2, 1'b0}, 21'h0, 1'b1, 1'b1, 1'b1, 3'd1, 38'h77, 38'h78, 1'b1);

        // Nine distinct tags in set 3. The first eight fill ways 0..7; the ninth replaces way 0.
        for (int i = 1; i <= 9; i++) begin
            wa = pair(46'(i), 5'd3);
            do_write(wa, 38'(i), 38'(i + 'h1000), 38'(i + 'h2000), 1'b0, 3'd0, 1'b0, 1'b0);
            if (i == 8) begin
                lookup("fill_way0", {pair(46'd1, 5'd3), 1'b0}, 21'h0, 1'b1, 1'b1,
                       1'b1, 3'd0, 38'd1, 38'h1001, 1'b1);
                lookup("fill_way7", {pair(46'd8, 5'd3), 1'b0}, 21'h0, 1'b1, 1'b1,
                       1'b1, 3'd7, 38'd8, 38'h1008, 1'b1);
            end
        end
        lookup("evicted_tag1", {pair(46'd1, 5'd3), 1'b0}, 21'h0, 1'b1, 1'b1, 1'b0, 3'd0, z, z, 1'b1);
        lookup("ninth_way0",   {pair(46'd9, 5'd3), 1'b0}, 21'h0, 1'b1, 1'b1,
               1'b1, 3'd0, 38'd9, 38'h1009, 1'b1);
        lookup("tag2_way1",    {pair(46'd2, 5'd3), 1'b1}, 21'h0, 1'b1, 1'b1,
               1'b1, 3'd1, 38'h1002, 38'h2002, 1'b1);

        // Sticky forced entry in way 5. The round-robin pointer is now 1. Eight more writes land in
        // ways 1,2,3,4,6 (pointer 5 skips sticky way 5),6,7,0.
        do_write(pair(46'd100, 5'd3), 38'h55, 38'h56, 38'h57, 1'b1, 3'd5, 1'b1, 1'b0);
        for (int i = 101; i <= 108; i++) begin
            wa = pair(46'(i), 5'd3);
            do_write(wa, 38'(i), 38'(i + 'h1000), 38'(i + 'h2000), 1'b0, 3'd0, 1'b0, 1'b0);
        end
        lookup("sticky_kept", {pair(46'd100, 5'd3), 1'b0}, 21'h0, 1'b1, 1'b1,
               1'b1, 3'd5, 38'h55, 38'h56, 1'b1);
        lookup("rr_skip_lost", {pair(46'd105, 5'd3), 1'b0}, 21'h0, 1'b1, 1'b1, 1'b0, 3'd0, z, z, 1'b1);
        lookup("rr_way6",     {pair(46'd106, 5'd3), 1'b0}, 21'h0, 1'b1, 1'b1,
               1'b1, 3'd6, 38'd106, 38'd106 + 38'h1000, 1'b1);
        lookup("rr_way4",     {pair(46'd104, 5'd3), 1'b0}, 21'h0, 1'b1, 1'b1,
               1'b1, 3'd4, 38'd104, 38'd104 + 38'h1000, 1'b1);
        lookup("rr_wrap_way0", {pair(46'd108, 5'd3), 1'b0}, 21'h0, 1'b1, 1'b1,
               1'b1, 3'd0, 38'd108, 38'd108 + 38'h1000, 1'b1);

        // Write the same tag twice. The second write uses write_invl and a forced different way,
        // so only the newer way hits.
        wa = pair(46'h3ABC, 5'd10);
        do_write(wa, 38'h111, 38'h112, 38'h113, 1'b1, 3'd2, 1'b0, 1'b0);
        lookup("invl_first", {wa, 1'b0}, 21'h0, 1'b1, 1'b1, 1'b1, 3'd2, 38'h111, 38'h112, 1'b1);
        do_write(wa, 38'h221, 38'h222, 38'h223, 1'b1, 3'd6, 1'b0, 1'b1);
        lookup("invl_newer", {wa, 1'b1}, 21'h0, 1'b1, 1'b1, 1'b1, 3'd6, 38'h222, 38'h223, 1'b1);

        // Reset takes priority over a simultaneous write and clears all entries.
        @(negedge clk);
        rst = 1'b1;
        set_write(pair(46'h55, 5'd12), 38'h9, 38'h9, 38'h9, 1'b0, 3'd0, 1'b0, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        bus.write_wen = 1'b0;
        lookup("rst_clears", {p1, 1'b0}, 21'h0, 1'b1, 1'b1, 1'b0, 3'd0, z, z, 1'b1);
        lookup("rst_beats_wr", {pair(46'h55, 5'd12), 1'b0}, 21'h0, 1'b1, 1'b1, 1'b0, 3'd0, z, z, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
